fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register consumed by the decode/control stage. It applies the decode stage's next-PC selection (`pcsource`, branch/jump targets), its load-use stall, and its instruction-cancel flush. A one-entry skid buffer absorbs a memory response that lands during a stall.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/fetch_skid.sv | 38 +++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// Module : mips_pkg
// Brief  : Shared MIPS pipeline constants, fetch state encoding and PC helper.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

   localparam int INST_W = 32;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_J   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_HOLD    = 2'd2,
      S_DISCARD = 2'd3
   } fetch_state_t;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid.sv
//------------------------------------------------------------------------------
// Module : fetch_skid
// Brief  : One-entry holding register for an instruction and its PC+4.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_skid
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [INST_W-1:0] load_inst,
   input  logic [31:0]       load_pc4,
   output logic [INST_W-1:0] inst,
   output logic [31:0]       pc4,
   output logic              valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst  <= '0;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         inst  <= load_inst;
         pc4   <= load_pc4;
         valid <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module : fetch_stage
// Brief  : MIPS IF stage: PC, imem req/ack fetch, IF/ID register, skid buffer.
//          Optional counters enabled by defining FETCH_PERF_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [1:0]        pcsource,
   input  logic [31:0]       bpc,
   input  logic [31:0]       jpc,
   input  logic              stall,
   input  logic              flush,
   output logic              imem_req,
   output logic [31:0]       imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [31:0]       pc_if,
   output logic [INST_W-1:0] inst_id,
   output logic [31:0]       pc4_id,
   output logic              valid_id
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall
`endif
);

   fetch_state_t state, next_state;

   logic              redirect;
   logic [31:0]       target;
   logic [31:0]       target_q;
   logic [31:0]       pc_next;
   logic              pc_load;
   logic              tgt_load;
   logic              id_load;
   logic              id_from_skid;
   logic              squash;
   logic              skid_load;
   logic              skid_clear;
   logic [INST_W-1:0] skid_inst;
   logic [31:0]       skid_pc4;
   logic              skid_valid;

   assign redirect  = !stall && (pcsource != PCSRC_SEQ) && (pcsource != 2'b11);
   assign target    = (pcsource == PCSRC_BR) ? bpc : jpc;
   assign imem_addr = pc_if;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state   = state;
      imem_req     = 1'b0;
      pc_load      = 1'b0;
      pc_next      = pc_if;
      tgt_load     = 1'b0;
      id_load      = 1'b0;
      id_from_skid = 1'b0;
      squash       = 1'b0;
      skid_load    = 1'b0;
      skid_clear   = 1'b0;
      case (state)
         S_IDLE: next_state = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               if (redirect) begin
                  pc_load = 1'b1;
                  pc_next = target;
                  squash  = 1'b1;
               end else if (stall) begin
                  skid_load  = 1'b1;
                  next_state = S_HOLD;
               end else begin
                  id_load = 1'b1;
                  pc_load = 1'b1;
                  pc_next = pc_plus4(pc_if);
               end
            end else if (redirect) begin
               tgt_load   = 1'b1;
               squash     = 1'b1;
               next_state = S_DISCARD;
            end
         end
         S_HOLD: begin
            if (!stall) begin
               skid_clear = 1'b1;
               pc_load    = 1'b1;
               next_state = S_FETCH;
               if (redirect) begin
                  pc_next = target;
                  squash  = 1'b1;
               end else begin
                  id_load      = 1'b1;
                  id_from_skid = 1'b1;
                  pc_next      = pc_plus4(pc_if);
               end
            end
         end
         S_DISCARD: begin
            // Old address stays on the bus until memory answers; the word is dropped.
            imem_req = 1'b1;
            if (imem_ack) begin
               pc_load    = 1'b1;
               pc_next    = target_q;
               next_state = S_FETCH;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pc_if    <= RESET_PC;
         target_q <= '0;
      end else begin
         if (pc_load)  pc_if    <= pc_next;
         if (tgt_load) target_q <= target;
      end
   end

   // Without a stall, a cycle that loads nothing leaves a bubble for decode.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         inst_id  <= '0;
         pc4_id   <= '0;
         valid_id <= 1'b0;
      end else begin
         if (id_load) begin
            inst_id <= id_from_skid ? skid_inst : imem_rdata;
            pc4_id  <= id_from_skid ? skid_pc4  : pc_plus4(pc_if);
         end
         if (flush || squash) valid_id <= 1'b0;
         else if (id_load)    valid_id <= 1'b1;
         else if (!stall)     valid_id <= 1'b0;
      end
   end

   fetch_skid u_skid (
      .clk       (Clock),
      .rst       (Reset),
      .load      (skid_load),
      .clear     (skid_clear),
      .load_inst (imem_rdata),
      .load_pc4  (pc_plus4(pc_if)),
      .inst      (skid_inst),
      .pc4       (skid_pc4),
      .valid     (skid_valid)
   );

`ifdef FETCH_PERF_EN
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (id_load && !flush && !squash) perf_fetched <= perf_fetched + 32'd1;
         if (stall)                        perf_stall   <= perf_stall + 32'd1;
      end
   end
`endif

   logic unused_ok;
   assign unused_ok = skid_valid;

endmodule

`default_nettype wire
